tx_rate_pacer: RTL

TX_RATE_PACER -- requirements
Module: tx_rate_pacer

---
 rtl/tx_rate_pacer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/tx_rate_pacer.sv
// Token-bucket pacer: accrues fixed-point credit each RUN cycle and issues frame
// requests to the frame generator whenever a whole frame's wire cost is covered.
module tx_rate_pacer #(
    parameter int CREDIT_W = 24,
    parameter int MIN_LEN  = 60,
    parameter int MAX_LEN  = 1514,
    parameter int OVERHEAD = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [15:0]         rate,
    input  logic [10:0]         frame_len,
    input  logic [15:0]         burst_bytes,
    output logic                req_valid,
    output logic [10:0]         req_len,
    input  logic                req_ready,
    output logic                idle,
    output logic [31:0]         frames_sent,
    output logic [47:0]         bytes_sent,
    output logic [1:0]          state_dbg,
    output logic [CREDIT_W-1:0] credit_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [10:0] MIN_L = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L = 11'(MAX_LEN);

    state_t                state_q, state_d;
    logic [CREDIT_W-1:0]   credit_q, cap_q, cost_q;
    logic [15:0]           rate_q;
    logic [10:0]           len_q;
    logic                  armed_q;

    logic [10:0]           len_clamp;
    logic [CREDIT_W-1:0]   cost_in, burst_fx, cap_in, credit_nxt;
    logic [CREDIT_W:0]     sum;
    logic                  accepted, start_run;

    // Handshake: a request is transferred in any cycle where req_valid && req_ready;
    // once raised, req_valid and req_len stay unchanged until that transfer.
    assign accepted  = req_valid && req_ready;
    assign start_run = (state_q == IDLE) && start && !stop && armed_q;

    assign len_clamp = (frame_len < MIN_L) ? MIN_L :
                       (frame_len > MAX_L) ? MAX_L : frame_len;
    assign cost_in   = CREDIT_W'({12'(len_clamp) + 12'(OVERHEAD), 8'h00});
    assign burst_fx  = CREDIT_W'({burst_bytes, 8'h00});
    assign cap_in    = (burst_fx > cost_in) ? burst_fx : cost_in;

    // One extra bit so credit + rate never wraps before the cap clamp.
    assign sum        = {1'b0, credit_q} + (CREDIT_W+1)'(rate_q)
                        - (accepted ? {1'b0, cost_q} : '0);
    assign credit_nxt = (sum > {1'b0, cap_q}) ? cap_q : sum[CREDIT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_run) state_d = RUN;
            RUN:     if (stop || !start) state_d = DRAIN;
            DRAIN:   if (!req_valid || accepted) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q    <= '0;
            cap_q       <= '0;
            cost_q      <= '0;
            rate_q      <= '0;
            len_q       <= '0;
            armed_q     <= 1'b0;
            req_valid   <= 1'b0;
            frames_sent <= '0;
            bytes_sent  <= '0;
        end else begin
            // A new test needs the controller to show start low or stop high while idle.
            if (state_q != IDLE) begin
                armed_q <= 1'b0;
            end else if (!start || stop) begin
                armed_q <= 1'b1;
            end

            if (start_run) begin
                credit_q    <= '0;
                frames_sent <= '0;
                bytes_sent  <= '0;
                rate_q      <= rate;
                len_q       <= len_clamp;
                cost_q      <= cost_in;
                cap_q       <= cap_in;
                req_valid   <= 1'b0;
            end else begin
                if (accepted) begin
                    frames_sent <= frames_sent + 32'd1;
                    bytes_sent  <= bytes_sent + 48'(len_q);
                end
                case (state_q)
                    RUN: begin
                        credit_q <= credit_nxt;
                        if (!req_valid || accepted) begin
                            req_valid <= (credit_nxt >= cost_q);
                        end
                    end
                    DRAIN: begin
                        if (accepted) req_valid <= 1'b0;
                    end
                    default: req_valid <= 1'b0;
                endcase
            end
        end
    end

    assign req_len    = len_q;
    assign idle       = (state_q == IDLE);
    assign state_dbg  = state_q;
    assign credit_dbg = credit_q;

endmodule
